seq_det_1011: RTL and testbench

SEQ_DET_1011 -- requirements
Module: seq_det_1011

---
 rtl/seq_det_1011.sv | 67 ++++++
 tb/tb_seq_det_1011.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_det_1011.sv
// Serial "1011" detector with overlapping matches, a wrapping detection counter
// and a sticky overflow flag. All outputs come straight from registers.
module seq_det_1011 #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             din,
  input  logic             en,
  output logic             det,
  output logic [2:0]       state,
  output logic [3:0]       shreg,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t cur;
  state_t nxt;

  // Transition table; unused encodings fall back to S0.
  function automatic state_t next_of(input state_t s, input logic b);
    state_t n;
    n = S0;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S1 : S2;
      S2:      n = b ? S3 : S0;
      S3:      n = b ? S4 : S2;
      S4:      n = b ? S1 : S2;
      default: n = S0;
    endcase
    return n;
  endfunction

  assign nxt   = next_of(cur, din);
  assign state = cur;

  // det is registered alongside the state so it tracks (state == S4) exactly.
  always_ff @(posedge clk) begin
    if (r) begin
      cur   <= S0;
      det   <= 1'b0;
      shreg <= 4'b0000;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      cur   <= nxt;
      det   <= (nxt == S4);
      shreg <= {shreg[2:0], din};
      if (nxt == S4) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_MAX) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_1011.sv
// Scoreboard bench for seq_det_1011: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_seq_det_1011;

  logic       clk = 1'b0;
  logic       r   = 1'b0;
  logic       din = 1'b0;
  logic       en  = 1'b0;
  logic       det;
  logic [2:0] state;
  logic [3:0] shreg;
  logic [3:0] cnt;
  logic       ovf;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] state;
    logic       det;
    logic [3:0] shreg;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t q[$];

  seq_det_1011 #(.CNT_W(4)) dut (
    .clk   (clk),
    .r     (r),
    .din   (din),
    .en    (en),
    .det   (det),
    .state (state),
    .shreg (shreg),
    .cnt   (cnt),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are stable at the negedge following each active edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || state !== e.state || det !== e.det || shreg !== e.shreg ||
          cnt !== e.cnt || ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s cyc=%0d: got state=%0d det=%b shreg=%b cnt=%0d ovf=%b, want state=%0d det=%b shreg=%b cnt=%0d ovf=%b",
                 e.name, cyc, state, det, shreg, cnt, ovf,
                 e.state, e.det, e.shreg, e.cnt, e.ovf);
      end
    end
  end

  // Drive one edge and queue the outputs expected after it.
  task automatic step(input string name, input logic rr, input logic ee, input logic dd,
                      input logic [2:0] st, input logic dt, input logic [3:0] sh,
                      input logic [3:0] ct, input logic ov);
    exp_t e;
    r = rr; en = ee; din = dd;
    e.cyc = cyc + 1; e.name = name;
    e.state = st; e.det = dt; e.shreg = sh; e.cnt = ct; e.ovf = ov;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    step(name, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 4'd0, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset state, and reset dominating en/din.
    do_reset("reset");
    step("reset_prio", 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 4'b0000, 4'd0, 1'b0);

    // Single match, then en=0 holds everything including det.
    step("single_b1", 0, 1, 1, 3'd1, 0, 4'b0001, 4'd0, 0);
    step("single_b2", 0, 1, 0, 3'd2, 0, 4'b0010, 4'd0, 0);
    step("single_b3", 0, 1, 1, 3'd3, 0, 4'b0101, 4'd0, 0);
    step("single_b4", 0, 1, 1, 3'd4, 1, 4'b1011, 4'd1, 0);
    step("hold_det",  0, 0, 0, 3'd4, 1, 4'b1011, 4'd1, 0);

    // Overlapping matches 1011011.
    do_reset("ovl_reset");
    step("ovl_b1", 0, 1, 1, 3'd1, 0, 4'b0001, 4'd0, 0);
    step("ovl_b2", 0, 1, 0, 3'd2, 0, 4'b0010, 4'd0, 0);
    step("ovl_b3", 0, 1, 1, 3'd3, 0, 4'b0101, 4'd0, 0);
    step("ovl_b4", 0, 1, 1, 3'd4, 1, 4'b1011, 4'd1, 0);
    step("ovl_b5", 0, 1, 0, 3'd2, 0, 4'b0110, 4'd1, 0);
    step("ovl_b6", 0, 1, 1, 3'd3, 0, 4'b1101, 4'd1, 0);
    step("ovl_b7", 0, 1, 1, 3'd4, 1, 4'b1011, 4'd2, 0);

    // Enable gating across a partial match.
    do_reset("gate_reset");
    step("gate_b1",  0, 1, 1, 3'd1, 0, 4'b0001, 4'd0, 0);
    step("gate_b2",  0, 1, 0, 3'd2, 0, 4'b0010, 4'd0, 0);
    for (int i = 0; i < 3; i++)
      step("gate_hold", 0, 0, 1, 3'd2, 0, 4'b0010, 4'd0, 0);
    step("gate_b3",  0, 1, 1, 3'd3, 0, 4'b0101, 4'd0, 0);
    step("gate_b4",  0, 1, 1, 3'd4, 1, 4'b1011, 4'd1, 0);

    // Counter wrap over 16 matches; ovf is sticky afterwards.
    do_reset("wrap_reset");
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        step("wrap_b1", 0, 1, 1, 3'd1, 0, 4'b0001, 4'(i), 0);
        step("wrap_b2", 0, 1, 0, 3'd2, 0, 4'b0010, 4'(i), 0);
        step("wrap_b3", 0, 1, 1, 3'd3, 0, 4'b0101, 4'(i), 0);
      end else begin
        step("wrap_b1", 0, 1, 1, 3'd1, 0, 4'b0111, 4'(i), 0);
        step("wrap_b2", 0, 1, 0, 3'd2, 0, 4'b1110, 4'(i), 0);
        step("wrap_b3", 0, 1, 1, 3'd3, 0, 4'b1101, 4'(i), 0);
      end
      step("wrap_b4", 0, 1, 1, 3'd4, 1, 4'b1011, 4'(i + 1), (i == 15) ? 1'b1 : 1'b0);
    end
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] sh;
      logic [7:0] wide;
      wide = 8'b0000_1011 << k;
      sh = wide[3:0];
      step("wrap_sticky", 0, 1, 0, (k == 1) ? 3'd2 : 3'd0, 0, sh, 4'd0, 1);
    end

    // Reset in S3 drops the partial match and clears ovf.
    do_reset("mid_reset0");
    step("mid_b1", 0, 1, 1, 3'd1, 0, 4'b0001, 4'd0, 0);
    step("mid_b2", 0, 1, 0, 3'd2, 0, 4'b0010, 4'd0, 0);
    step("mid_b3", 0, 1, 1, 3'd3, 0, 4'b0101, 4'd0, 0);
    step("mid_rst", 1, 1, 1, 3'd0, 0, 4'b0000, 4'd0, 0);
    step("mid_after", 0, 1, 1, 3'd1, 0, 4'b0001, 4'd0, 0);

    // Non-matching stream 1110010.
    do_reset("nm_reset");
    step("nm_b1", 0, 1, 1, 3'd1, 0, 4'b0001, 4'd0, 0);
    step("nm_b2", 0, 1, 1, 3'd1, 0, 4'b0011, 4'd0, 0);
    step("nm_b3", 0, 1, 1, 3'd1, 0, 4'b0111, 4'd0, 0);
    step("nm_b4", 0, 1, 0, 3'd2, 0, 4'b1110, 4'd0, 0);
    step("nm_b5", 0, 1, 0, 3'd0, 0, 4'b1100, 4'd0, 0);
    step("nm_b6", 0, 1, 1, 3'd1, 0, 4'b1001, 4'd0, 0);
    step("nm_b7", 0, 1, 0, 3'd2, 0, 4'b0010, 4'd0, 0);

    // Let the monitor drain; anything left is a missed comparison.
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
